mc_ctrl_hs: RTL and testbench

//  Parametrised multi-cycle MIPS control FSM; successor of the fixed 5-state controller.

---
 rtl/mc_ctrl_hs.sv | 238 +++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with imem/dmem ready/req handshakes, bounded wait timeout and traps.
// Optional retired-instruction counter is built when CTRL_PERF_EN is defined.
//
// state  | meaning
// FETCH  | request instruction, load IR and PC+4 when imem_rdy
// DECODE | check opcode/funct against the supported set
// EXEC   | ALU operation, branch/jump PC update, link write for JAL/JALR
// MEM    | data memory access, wait for dmem_rdy
// WB     | register file write (ALU result or load data)
// TRAP   | illegal instruction or memory timeout, held until rst
module mc_ctrl_hs #(
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             PCWr,
    output logic [2:0]       npcSel,
    output logic             IRWr,
    output logic             GPRWr,
    output logic             DMWr,
    output logic [3:0]       AluOp,
    output logic             AluBsel,
    output logic [1:0]       GPRsel,
    output logic [1:0]       WDsel,
    output logic [1:0]       ExtOp,
    output logic             bmode,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    state_t          state, state_nx;
    logic [TO_W-1:0] wait_cnt, wait_nx;
    logic [1:0]      cause_nx;

    logic rtype, op_addu, op_subu, op_slt, op_jr, op_jalr;
    logic op_ori, op_lui, op_addi, op_addiu, op_lw, op_lb, op_sw, op_sb;
    logic op_beq, op_bne, op_j, op_jal;
    logic is_ralu, is_ialu, is_load, is_store, is_branch, is_jump, legal;
    logic [3:0] dec_alu;
    logic [1:0] dec_ext, dec_wd;

    assign rtype    = (opcode == 6'h00);
    assign op_addu  = rtype && (funct == 6'h21);
    assign op_subu  = rtype && (funct == 6'h23);
    assign op_slt   = rtype && (funct == 6'h2A);
    assign op_jr    = rtype && (funct == 6'h08);
    assign op_jalr  = rtype && (funct == 6'h09);
    assign op_ori   = (opcode == 6'h0D);
    assign op_lui   = (opcode == 6'h0F);
    assign op_addi  = (opcode == 6'h08);
    assign op_addiu = (opcode == 6'h09);
    assign op_lw    = (opcode == 6'h23);
    assign op_lb    = (opcode == 6'h20);
    assign op_sw    = (opcode == 6'h2B);
    assign op_sb    = (opcode == 6'h28);
    assign op_beq   = (opcode == 6'h04);
    assign op_bne   = (opcode == 6'h05);
    assign op_j     = (opcode == 6'h02);
    assign op_jal   = (opcode == 6'h03);

    assign is_ralu   = op_addu | op_subu | op_slt;
    assign is_ialu   = op_ori | op_lui | op_addi | op_addiu;
    assign is_load   = op_lw | op_lb;
    assign is_store  = op_sw | op_sb;
    assign is_branch = op_beq | op_bne;
    assign is_jump   = op_j | op_jal | op_jr | op_jalr;
    assign legal     = is_ralu | is_ialu | is_load | is_store | is_branch | is_jump;

    always_comb begin
        dec_alu = 4'hF;
        if (op_addu | op_addiu | is_load | is_store | is_jump) dec_alu = 4'h0;
        else if (op_subu | is_branch)                          dec_alu = 4'h1;
        else if (op_ori)                                       dec_alu = 4'h2;
        else if (op_lui)                                       dec_alu = 4'h3;
        else if (op_addi)                                      dec_alu = 4'h5;
        else if (op_slt)                                       dec_alu = 4'h6;

        dec_ext = 2'b11;
        if (op_ori | is_ralu | is_jump)                                 dec_ext = 2'b00;
        else if (op_lui)                                                dec_ext = 2'b10;
        else if (op_addi | op_addiu | is_load | is_store | is_branch)   dec_ext = 2'b01;

        if (is_load)                dec_wd = 2'b01;
        else if (op_jal | op_jalr)  dec_wd = 2'b10;
        else if (legal)             dec_wd = 2'b00;
        else                        dec_wd = 2'b11;
    end

    always_comb begin
        state_nx = state;
        cause_nx = trap_cause;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        PCWr     = 1'b0;
        npcSel   = 3'b000;
        IRWr     = 1'b0;
        GPRWr    = 1'b0;
        DMWr     = 1'b0;
        AluOp    = dec_alu;
        ExtOp    = dec_ext;
        WDsel    = dec_wd;
        GPRsel   = is_ralu ? 2'b01 : ((op_jal | op_jalr) ? 2'b10 : 2'b00);
        AluBsel  = is_ialu | is_load | is_store;
        bmode    = op_lb | op_sb;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                IRWr     = imem_rdy;
                PCWr     = imem_rdy;
                AluOp    = 4'hF;
                ExtOp    = 2'b11;
                WDsel    = 2'b11;
                GPRsel   = 2'b00;
                AluBsel  = 1'b0;
                bmode    = 1'b0;
                // rdy wins over a timeout reached in the same cycle
                if (imem_rdy) begin
                    state_nx = DECODE;
                end else if (wait_cnt == TO_MAX) begin
                    state_nx = TRAP;
                    cause_nx = 2'b10;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_nx = EXEC;
                end else begin
                    state_nx = TRAP;
                    cause_nx = 2'b01;
                end
            end
            EXEC: begin
                state_nx = FETCH;
                if (is_branch) begin
                    PCWr   = (op_beq & zero) | (op_bne & ~zero);
                    npcSel = 3'b001;
                end else if (op_j | op_jal) begin
                    PCWr   = 1'b1;
                    npcSel = 3'b010;
                end else if (op_jr | op_jalr) begin
                    PCWr   = 1'b1;
                    npcSel = 3'b100;
                end
                GPRWr = op_jal | op_jalr;
                if (is_ralu | is_ialu)       state_nx = WB;
                else if (is_load | is_store) state_nx = MEM;
            end
            MEM: begin
                dmem_req = 1'b1;
                DMWr     = is_store & dmem_rdy;
                if (dmem_rdy) begin
                    state_nx = is_load ? WB : FETCH;
                end else if (wait_cnt == TO_MAX) begin
                    state_nx = TRAP;
                    cause_nx = 2'b11;
                end
            end
            WB: begin
                GPRWr    = 1'b1;
                state_nx = FETCH;
            end
            TRAP: begin
                AluOp   = 4'hF;
                ExtOp   = 2'b11;
                WDsel   = 2'b11;
                AluBsel = 1'b0;
                bmode   = 1'b0;
            end
            default: state_nx = FETCH;
        endcase

        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            GPRWr    = 1'b0;
            DMWr     = 1'b0;
        end
    end

    always_comb begin
        wait_nx = wait_cnt;
        if (state_nx != state)
            wait_nx = '0;
        else if (((state == FETCH && !imem_rdy) || (state == MEM && !dmem_rdy)) && wait_cnt != '1)
            wait_nx = wait_cnt + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_nx;
            trap       <= trap | (state_nx == TRAP);
            trap_cause <= cause_nx;
        end
    end

`ifdef CTRL_PERF_EN
    logic retire;
    assign retire = (state_nx == FETCH) && (state == EXEC || state == MEM || state == WB);

    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs: per-instruction expected cycle traces built from the instruction class
// and memory latencies, applied from a decode table, hand-picked corner cases and random mixes.
module tb_mc_ctrl_hs;

`ifdef CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = '0, funct = '0;
    logic        zero = 1'b0, imem_rdy = 1'b0, dmem_rdy = 1'b0;
    logic        imem_req, dmem_req, PCWr, IRWr, GPRWr, DMWr, AluBsel, bmode, trap;
    logic [2:0]  npcSel;
    logic [3:0]  AluOp;
    logic [1:0]  GPRsel, WDsel, ExtOp, trap_cause;
    logic [31:0] instret;

    mc_ctrl_hs #(.TO_W(4), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .imem_req(imem_req), .dmem_req(dmem_req),
        .PCWr(PCWr), .npcSel(npcSel), .IRWr(IRWr), .GPRWr(GPRWr), .DMWr(DMWr),
        .AluOp(AluOp), .AluBsel(AluBsel), .GPRsel(GPRsel), .WDsel(WDsel), .ExtOp(ExtOp),
        .bmode(bmode), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, dmem_req, pcwr;
        logic [2:0] npc;
        logic       irwr, gprwr, dmwr;
        logic [1:0] gsel, wd;
        logic       trap;
        logic [1:0] cause;
        logic [3:0] alu;
        logic [1:0] ext;
        logic       bsel, bm;
    } ov_t;

    // cls: 0 R-type ALU, 1 I-type ALU, 2 load, 3 store, 4 branch/jump, 5 illegal
    typedef struct {
        string      nm;
        logic [5:0] op, fn;
        logic       zr;
        int         cls;
        logic       pcwr;
        logic [2:0] npc;
        logic       nchk, gw;
        logic [3:0] alu;
        logic       achk;
        logic [1:0] ext;
        logic       echk;
    } row_t;

    typedef struct {
        string nm;
        logic  ir, dr, rs;
        ov_t   e, m;
        bit    fin;
    } cyc_t;

    row_t        tbl[$];
    cyc_t        q[$];
    int          n_tests = 0, n_fail = 0;
    int unsigned retired = 0;

    function automatic ov_t act();
        ov_t a;
        a.imem_req = imem_req; a.dmem_req = dmem_req; a.pcwr = PCWr; a.npc = npcSel;
        a.irwr = IRWr; a.gprwr = GPRWr; a.dmwr = DMWr; a.gsel = GPRsel; a.wd = WDsel;
        a.trap = trap; a.cause = trap_cause; a.alu = AluOp; a.ext = ExtOp;
        a.bsel = AluBsel; a.bm = bmode;
        return a;
    endfunction

    function automatic ov_t base_mask();
        ov_t m;
        m = '0;
        m.imem_req = 1'b1; m.dmem_req = 1'b1; m.pcwr = 1'b1; m.irwr = 1'b1;
        m.gprwr = 1'b1; m.dmwr = 1'b1; m.trap = 1'b1; m.cause = 2'b11;
        return m;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int pick_wait();
        int s;
        s = int'($urandom_range(0, 15));
        if (s == 0) return 16;
        if (s == 1) return 15;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string nm, input ov_t e, input ov_t m, input bit ic);
        ov_t a;
        logic [31:0] ie;
        a = act();
        n_tests++;
        if (((a ^ e) & m) != '0) begin
            n_fail++;
            $display("FAIL %s: outputs got %h required %h (mask %h)", nm, a, e, m);
        end
        if (ic) begin
            ie = PERF ? retired : 32'd0;
            n_tests++;
            if (instret !== ie) begin
                n_fail++;
                $display("FAIL %s/instret: got %0d required %0d", nm, instret, ie);
            end
        end
    endtask

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic zr,
                       input int cls, input logic pcwr, input logic [2:0] npc, input logic nchk,
                       input logic gw, input logic [3:0] alu, input logic achk,
                       input logic [1:0] ext, input logic echk);
        row_t r;
        r.nm = nm; r.op = op; r.fn = fn; r.zr = zr; r.cls = cls; r.pcwr = pcwr; r.npc = npc;
        r.nchk = nchk; r.gw = gw; r.alu = alu; r.achk = achk; r.ext = ext; r.echk = echk;
        tbl.push_back(r);
    endtask

    task automatic push(input string nm, input logic ir, input logic dr, input logic rs,
                        input ov_t e, input ov_t m, input bit fin);
        cyc_t c;
        c.nm = nm; c.ir = ir; c.dr = dr; c.rs = rs; c.e = e; c.m = m; c.fin = fin;
        q.push_back(c);
    endtask

    task automatic do_reset();
        ov_t m;
        m = base_mask();
        m.trap = 1'b0; m.cause = 2'b00;
        rst = 1'b1; imem_rdy = 1'b1; dmem_rdy = 1'b1;
        @(negedge clk);
        chk("rst_gate", '0, m, 1'b0);
        @(posedge clk); #1;
        retired = 0;
        @(negedge clk);
        chk("rst_state", '0, base_mask(), 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_q(input string tag);
        for (int k = 0; k < q.size(); k++) begin
            rst = q[k].rs; imem_rdy = q[k].ir; dmem_rdy = q[k].dr;
            @(negedge clk);
            chk($sformatf("%s/%s%0d", tag, q[k].nm, k), q[k].e, q[k].m, 1'b1);
            @(posedge clk); #1;
            if (q[k].fin) retired++;
            if (q[k].rs)  retired = 0;
        end
        rst = 1'b0;
    endtask

    // Expected trace of one instruction: fetch waits, decode, exec, optional mem waits, wb, trap.
    task automatic run_instr(input row_t r, input int fw, input int mw, input bit rm);
        ov_t e, m, mb;
        int  tc;
        bit  byte_acc;
        tc = 0;
        byte_acc = (r.op == 6'h20) || (r.op == 6'h28);
        mb = base_mask();
        q.delete();
        for (int i = 0; i <= fw && i < 16; i++) begin
            e = '0; m = mb;
            m.npc = '1; m.wd = '1; m.alu = '1; m.ext = '1;
            e.imem_req = 1'b1; e.wd = 2'b11; e.alu = 4'hF; e.ext = 2'b11;
            e.pcwr = (i == fw); e.irwr = (i == fw);
            push("fetch", (i == fw), rnd(), 1'b0, e, m, 1'b0);
        end
        if (fw >= 16) tc = 2;
        else begin
            push("decode", rnd(), rnd(), 1'b0, '0, mb, 1'b0);
            if (r.cls == 5) tc = 1;
            else begin
                e = '0; m = mb;
                e.pcwr = r.pcwr; e.gprwr = r.gw;
                if (r.nchk) begin m.npc = '1; e.npc = r.npc; end
                if (r.gw)   begin m.gsel = '1; m.wd = '1; e.gsel = 2'b10; e.wd = 2'b10; end
                if (r.achk) begin m.alu = '1; e.alu = r.alu; end
                if (r.echk) begin m.ext = '1; e.ext = r.ext; end
                if (r.cls <= 3) begin m.bsel = 1'b1; e.bsel = (r.cls != 0); end
                push("exec", rnd(), rnd(), 1'b0, e, m, r.cls == 4);
                if (r.cls == 2 || r.cls == 3) begin
                    for (int i = 0; i <= mw && i < 16; i++) begin
                        if (rm) begin
                            push("rst_mem", rnd(), 1'b1, 1'b1, '0, mb, 1'b0);
                            break;
                        end
                        e = '0; m = mb; m.bm = 1'b1;
                        e.dmem_req = 1'b1; e.bm = byte_acc;
                        e.dmwr = (i == mw) && (r.cls == 3);
                        push("mem", rnd(), (i == mw), 1'b0, e, m, (i == mw) && (r.cls == 3));
                    end
                    if (mw >= 16 && !rm) tc = 3;
                end
                if (r.cls <= 2 && tc == 0 && !rm) begin
                    e = '0; m = mb; m.gsel = '1; m.wd = '1;
                    e.gprwr = 1'b1;
                    e.wd   = (r.cls == 2) ? 2'b01 : 2'b00;
                    e.gsel = (r.cls == 0) ? 2'b01 : 2'b00;
                    push("wb", rnd(), rnd(), 1'b0, e, m, 1'b1);
                end
            end
        end
        if (tc != 0) begin
            for (int i = 0; i < 3; i++) begin
                e = '0; m = mb; m.wd = '1; m.alu = '1; m.ext = '1;
                e.trap = 1'b1; e.cause = 2'(tc); e.wd = 2'b11; e.alu = 4'hF; e.ext = 2'b11;
                push("trap", rnd(), rnd(), 1'b0, e, m, 1'b0);
            end
        end
        opcode = r.op; funct = r.fn; zero = r.zr;
        run_q($sformatf("%s(f%0d,m%0d)", r.nm, fw, mw));
        if (tc != 0) do_reset();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //  name     op     fn     z  cls pc npc     nc gw alu  ac ext    ec
        add("ADDU",  6'h00, 6'h21, 0, 0, 0, 3'b000, 0, 0, 4'h0, 1, 2'b00, 0);
        add("SUBU",  6'h00, 6'h23, 0, 0, 0, 3'b000, 0, 0, 4'h1, 1, 2'b00, 0);
        add("SLT",   6'h00, 6'h2A, 0, 0, 0, 3'b000, 0, 0, 4'h6, 1, 2'b00, 0);
        add("JR",    6'h00, 6'h08, 0, 4, 1, 3'b100, 1, 0, 4'h0, 0, 2'b00, 0);
        add("JALR",  6'h00, 6'h09, 0, 4, 1, 3'b100, 1, 1, 4'h0, 0, 2'b00, 0);
        add("ORI",   6'h0D, 6'h15, 0, 1, 0, 3'b000, 0, 0, 4'h2, 1, 2'b00, 1);
        add("LUI",   6'h0F, 6'h00, 1, 1, 0, 3'b000, 0, 0, 4'h3, 1, 2'b10, 1);
        add("ADDI",  6'h08, 6'h3F, 0, 1, 0, 3'b000, 0, 0, 4'h5, 1, 2'b01, 1);
        add("ADDIU", 6'h09, 6'h21, 0, 1, 0, 3'b000, 0, 0, 4'h0, 1, 2'b01, 1);
        add("LW",    6'h23, 6'h00, 0, 2, 0, 3'b000, 0, 0, 4'h0, 0, 2'b00, 0);
        add("LB",    6'h20, 6'h00, 1, 2, 0, 3'b000, 0, 0, 4'h0, 0, 2'b00, 0);
        add("SW",    6'h2B, 6'h00, 0, 3, 0, 3'b000, 0, 0, 4'h0, 0, 2'b00, 0);
        add("SB",    6'h28, 6'h00, 0, 3, 0, 3'b000, 0, 0, 4'h0, 0, 2'b00, 0);
        add("BEQz1", 6'h04, 6'h00, 1, 4, 1, 3'b001, 1, 0, 4'h1, 1, 2'b01, 1);
        add("BEQz0", 6'h04, 6'h00, 0, 4, 0, 3'b001, 1, 0, 4'h1, 1, 2'b01, 1);
        add("BNEz0", 6'h05, 6'h00, 0, 4, 1, 3'b001, 1, 0, 4'h1, 1, 2'b01, 1);
        add("BNEz1", 6'h05, 6'h00, 1, 4, 0, 3'b001, 1, 0, 4'h1, 1, 2'b01, 1);
        add("J",     6'h02, 6'h00, 0, 4, 1, 3'b010, 1, 0, 4'h0, 0, 2'b00, 0);
        add("JAL",   6'h03, 6'h00, 0, 4, 1, 3'b010, 1, 1, 4'h0, 0, 2'b00, 0);
        add("ILL3F", 6'h3F, 6'h00, 0, 5, 0, 3'b000, 0, 0, 4'h0, 0, 2'b00, 0);
        add("ADD",   6'h00, 6'h20, 0, 5, 0, 3'b000, 0, 0, 4'h0, 0, 2'b00, 0);
        add("BLEZ",  6'h06, 6'h00, 0, 5, 0, 3'b000, 0, 0, 4'h0, 0, 2'b00, 0);

        do_reset();

        foreach (tbl[i]) run_instr(tbl[i], 0, 0, 1'b0);

        run_instr(tbl[9],  0, 3,  1'b0);   // LW: dmem_rdy low 3 cycles
        run_instr(tbl[9],  2, 15, 1'b0);   // LW: rdy on the timeout cycle wins
        run_instr(tbl[11], 0, 16, 1'b0);   // SW: dmem timeout, DMWr never set
        run_instr(tbl[0],  15, 0, 1'b0);   // ADDU: imem rdy on the timeout cycle
        run_instr(tbl[0],  16, 0, 1'b0);   // imem timeout
        run_instr(tbl[12], 1, 0,  1'b1);   // SB: rst while MEM with dmem_rdy high
        run_instr(tbl[18], 0, 0,  1'b0);   // JAL straight after the mid-MEM reset

        for (int n = 0; n < 150; n++)
            run_instr(tbl[$urandom_range(0, tbl.size() - 1)], pick_wait(), pick_wait(), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
